ecc_apb_initiator: RTL

APB initiator that drives one ECC encoder/decoder responder through its four-register map and returns the result to a local command/response interface. It accepts one command at a time (mode, codeword width, data, noise) and programs the responder's registers with CTRL written last, which starts the operation. It then waits for operation_done and captures data_out and num_of_errors. It sits between a test sequencer or host engine and the ECC core in the system-level wrapper.

---
 rtl/ecc_apb_initiator_if.sv | 41 ++++
 rtl/ecc_apb_initiator.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ecc_apb_initiator_if.sv
// Command/response, APB and ECC-responder signals of ecc_apb_initiator, grouped.
// master = the initiator; slave = the host sequencer plus the APB responder side.
interface ecc_apb_initiator_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_mode;
    logic [1:0]                 cmd_width;
    logic [AMBA_WORD-1:0]       cmd_data;
    logic [AMBA_WORD-1:0]       cmd_noise;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic [1:0]                 rsp_errors;
    logic [1:0]                 rsp_status;

    modport master (
        input  cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
        input  operation_done, data_out, num_of_errors, rsp_ready,
        output cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output rsp_valid, rsp_data, rsp_errors, rsp_status
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
        output operation_done, data_out, num_of_errors, rsp_ready,
        input  cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  rsp_valid, rsp_data, rsp_errors, rsp_status
    );
endinterface

// File: rtl/ecc_apb_initiator.sv
// APB initiator: programs the ECC responder (CTRL last), waits for done or timeout, returns a response.
// 6/8 cycles accept-to-CTRL-ACCESS; one command in flight, held in RESP until rsp_ready.
module ecc_apb_initiator #(
    parameter int                          AMBA_ADDR_WIDTH = 20,
    parameter int                          AMBA_WORD       = 32,
    parameter int                          DATA_WIDTH      = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
    parameter int                          TIMEOUT_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_apb_initiator_if.master  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

    state_t               state;
    logic [1:0]           mode_q;
    logic [1:0]           width_q;
    logic [AMBA_WORD-1:0] data_q;
    logic [AMBA_WORD-1:0] noise_q;
    logic [1:0]           widx;
    logic [CNT_W-1:0]     tcnt;

    // Write index order: 0 CODEWORD_WIDTH, 1 NOISE, 2 DATA_IN, 3 CTRL.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] wr_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return BASE_ADDR + AMBA_ADDR_WIDTH'(8);
            2'd1:    return BASE_ADDR + AMBA_ADDR_WIDTH'(12);
            2'd2:    return BASE_ADDR + AMBA_ADDR_WIDTH'(4);
            default: return BASE_ADDR;
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] wr_data(input logic [1:0] idx, input logic [1:0] mode,
                                                     input logic [1:0] width, input logic [AMBA_WORD-1:0] data,
                                                     input logic [AMBA_WORD-1:0] noise);
        case (idx)
            2'd0:    return {{(AMBA_WORD-2){1'b0}}, width};
            2'd1:    return noise;
            2'd2:    return data;
            default: return {{(AMBA_WORD-2){1'b0}}, mode};
        endcase
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx, input logic [1:0] mode);
        if (idx == 2'd0 && mode != 2'b10) return 2'd2;
        return idx + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            width_q        <= '0;
            data_q         <= '0;
            noise_q        <= '0;
            widx           <= '0;
            tcnt           <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.PADDR      <= '0;
            bus.PWDATA     <= '0;
            bus.PSEL       <= 1'b0;
            bus.PENABLE    <= 1'b0;
            bus.PWRITE     <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_errors <= '0;
            bus.rsp_status <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    mode_q        <= bus.cmd_mode;
                    width_q       <= bus.cmd_width;
                    data_q        <= bus.cmd_data;
                    noise_q       <= bus.cmd_noise;
                    bus.cmd_ready <= 1'b0;
                    if (bus.cmd_mode == 2'b11) begin
                        state          <= RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_data   <= '0;
                        bus.rsp_errors <= '0;
                        bus.rsp_status <= 2'b10;
                    end else begin
                        state       <= SETUP;
                        widx        <= 2'd0;
                        bus.PSEL    <= 1'b1;
                        bus.PWRITE  <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        bus.PADDR   <= wr_addr(2'd0);
                        bus.PWDATA  <= wr_data(2'd0, bus.cmd_mode, bus.cmd_width, bus.cmd_data, bus.cmd_noise);
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    bus.PENABLE <= 1'b0;
                    if (widx == 2'd3) begin
                        bus.PSEL   <= 1'b0;
                        bus.PWRITE <= 1'b0;
                        tcnt       <= '0;
                        state      <= WAIT_DONE;
                    end else begin
                        widx       <= next_idx(widx, mode_q);
                        bus.PADDR  <= wr_addr(next_idx(widx, mode_q));
                        bus.PWDATA <= wr_data(next_idx(widx, mode_q), mode_q, width_q, data_q, noise_q);
                        state      <= SETUP;
                    end
                end
                WAIT_DONE: begin
                    // A done pulse on the last counted cycle still beats the timeout.
                    if (bus.operation_done) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_data   <= bus.data_out;
                        bus.rsp_errors <= bus.num_of_errors;
                        bus.rsp_status <= 2'b00;
                        state          <= RESP;
                    end else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_data   <= '0;
                        bus.rsp_errors <= '0;
                        bus.rsp_status <= 2'b01;
                        state          <= RESP;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
